// File: rtl/vedic_pkg.sv
// Shared constants and elaboration helpers for the pipelined Vedic multiplier.
package vedic_pkg;

  localparam int MIN_WIDTH = 4;
  localparam int MAX_WIDTH = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic int vedic_half(input int w);
    return w / 2;
  endfunction

  function automatic bit width_ok(input int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH) && ((32'sd1 << clog2(w)) == w);
  endfunction

endpackage

// File: rtl/vedic_mul_comb.sv
// Recursive combinational Urdhva-Tiryagbhyam multiplier, W x W -> 2W unsigned.
module vedic_mul_comb
  import vedic_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  if (W == 2) begin : g_base
    logic pp00_s, pp10_s, pp01_s, pp11_s, c1_s;

    assign pp00_s = a[0] & b[0];
    assign pp10_s = a[1] & b[0];
    assign pp01_s = a[0] & b[1];
    assign pp11_s = a[1] & b[1];
    assign c1_s   = pp10_s & pp01_s;
    assign p      = {pp11_s & c1_s, pp11_s ^ c1_s, pp10_s ^ pp01_s, pp00_s};
  end else begin : g_rec
    localparam int H = vedic_half(W);

    logic [W-1:0]   q_ll_s, q_hl_s, q_lh_s, q_hh_s;
    logic [W:0]     mid_s;
    logic [2*W-1:0] mid_ext_s;

    vedic_mul_comb #(.W(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(q_ll_s));
    vedic_mul_comb #(.W(H)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(q_hl_s));
    vedic_mul_comb #(.W(H)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(q_lh_s));
    vedic_mul_comb #(.W(H)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(q_hh_s));

    // Cross terms are summed one bit wider so their carry is never dropped.
    assign mid_s     = {1'b0, q_hl_s} + {1'b0, q_lh_s};
    assign mid_ext_s = {{(W-1){1'b0}}, mid_s} << H;
    assign p         = {q_hh_s, q_ll_s} + mid_ext_s;
  end

endmodule

// File: rtl/vedic_mul_pipe.sv
// Two-stage pipelined signed/unsigned Vedic multiplier with valid/ready streaming.
module vedic_mul_pipe
  import vedic_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int OUT_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_p
);

  localparam int H = vedic_half(WIDTH);
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [OUT_W-1:0] ONE_P = {{(OUT_W-1){1'b0}}, 1'b1};

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("vedic_mul_pipe: WIDTH must be a power of two in 4..16");
  end

  logic             adv_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s;
  logic             neg_s;
  logic [WIDTH-1:0] q_ll_s, q_hl_s, q_lh_s, q_hh_s;

  logic [WIDTH-1:0] q_ll_d, q_hl_d, q_lh_d, q_hh_d;
  logic [WIDTH-1:0] q_ll_q, q_hl_q, q_lh_q, q_hh_q;
  logic             neg_d, neg_q, s1_valid_d, s1_valid_q;
  logic [WIDTH:0]   mid_s;
  logic [OUT_W-1:0] sum_s;
  logic [OUT_W-1:0] out_p_d, out_p_q;
  logic             out_valid_d, out_valid_q;

  // Whole pipeline moves only when the output slot is empty or being drained.
  assign adv_s     = ~out_valid_q | out_ready;
  assign in_ready  = adv_s;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;

  // Stage 0: magnitudes and result sign; 2^(W-1) still fits as an unsigned magnitude.
  always_comb begin
    a_mag_s = in_a;
    b_mag_s = in_b;
    neg_s   = 1'b0;
    if (in_signed) begin
      a_mag_s = in_a[WIDTH-1] ? (~in_a + ONE_W) : in_a;
      b_mag_s = in_b[WIDTH-1] ? (~in_b + ONE_W) : in_b;
      neg_s   = in_a[WIDTH-1] ^ in_b[WIDTH-1];
    end else begin
      a_mag_s = in_a;
      b_mag_s = in_b;
      neg_s   = 1'b0;
    end
  end

  vedic_mul_comb #(.W(H)) u_q_ll (.a(a_mag_s[H-1:0]),     .b(b_mag_s[H-1:0]),     .p(q_ll_s));
  vedic_mul_comb #(.W(H)) u_q_hl (.a(a_mag_s[WIDTH-1:H]), .b(b_mag_s[H-1:0]),     .p(q_hl_s));
  vedic_mul_comb #(.W(H)) u_q_lh (.a(a_mag_s[H-1:0]),     .b(b_mag_s[WIDTH-1:H]), .p(q_lh_s));
  vedic_mul_comb #(.W(H)) u_q_hh (.a(a_mag_s[WIDTH-1:H]), .b(b_mag_s[WIDTH-1:H]), .p(q_hh_s));

  // Stage 1 next-state: load quarter products on advance, otherwise hold.
  always_comb begin
    q_ll_d     = q_ll_q;
    q_hl_d     = q_hl_q;
    q_lh_d     = q_lh_q;
    q_hh_d     = q_hh_q;
    neg_d      = neg_q;
    s1_valid_d = s1_valid_q;
    if (adv_s) begin
      q_ll_d     = q_ll_s;
      q_hl_d     = q_hl_s;
      q_lh_d     = q_lh_s;
      q_hh_d     = q_hh_s;
      neg_d      = neg_s;
      s1_valid_d = in_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2 next-state: recombine quarters, reapply sign; negating zero stays zero.
  always_comb begin
    mid_s       = {1'b0, q_hl_q} + {1'b0, q_lh_q};
    sum_s       = {q_hh_q, q_ll_q} + ({{(WIDTH-1){1'b0}}, mid_s} << H);
    out_p_d     = out_p_q;
    out_valid_d = out_valid_q;
    if (adv_s) begin
      out_p_d     = neg_q ? (~sum_s + ONE_P) : sum_s;
      out_valid_d = s1_valid_q;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_ll_q      <= {WIDTH{1'b0}};
      q_hl_q      <= {WIDTH{1'b0}};
      q_lh_q      <= {WIDTH{1'b0}};
      q_hh_q      <= {WIDTH{1'b0}};
      neg_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      out_p_q     <= {OUT_W{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      q_ll_q      <= q_ll_d;
      q_hl_q      <= q_hl_d;
      q_lh_q      <= q_lh_d;
      q_hh_q      <= q_hh_d;
      neg_q       <= neg_d;
      s1_valid_q  <= s1_valid_d;
      out_p_q     <= out_p_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Self-checking bench: directed vectors and sequences at WIDTH=8, random streams at WIDTH=4/8/16.
module tb_vedic_mul_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   rnd_go = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Golden product: plain integer multiply of the interpreted operands, truncated to 2w bits.
  function automatic logic [31:0] ref_mul(input int w, input longint ua, input longint ub, input bit sg);
    longint x, y, r, m;
    x = ua;
    y = ub;
    if (sg) begin
      if (x >= (64'sd1 << (w - 1))) x = x - (64'sd1 << w);
      if (y >= (64'sd1 << (w - 1))) y = y - (64'sd1 << w);
    end
    r = x * y;
    m = (64'sd1 << (2 * w)) - 64'sd1;
    r = r & m;
    return r[31:0];
  endfunction

  // ---------------- main WIDTH=8 instance ----------------
  logic [7:0]  m_a = 8'd0, m_b = 8'd0;
  logic        m_s = 1'b0, m_iv = 1'b0, m_ordy = 1'b1;
  logic        m_ov, m_irdy;
  logic [15:0] m_p;
  logic [15:0] m_q[$];
  int          m_outs = 0;

  vedic_mul_pipe #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(m_iv), .in_ready(m_irdy), .in_a(m_a), .in_b(m_b),
    .in_signed(m_s), .out_valid(m_ov), .out_ready(m_ordy), .out_p(m_p)
  );

  // Scoreboard: handshakes seen at the negedge complete at the following posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_q.delete();
      end else begin
        if (m_ov && m_ordy) begin
          m_outs++;
          if (m_q.size() == 0) chk("sb_unexpected_out", 32'd1, 32'd0);
          else chk("sb_p", 32'(m_p), 32'(m_q.pop_front()));
        end
        if (m_iv && m_irdy) m_q.push_back(ref_mul(8, longint'(m_a), longint'(m_b), m_s)); 
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s);
    bit ok;
    ok = 1'b0;
    m_a = a; m_b = b; m_s = s; m_iv = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (m_irdy) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    m_iv = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[10];
  bit   sent_done;
  logic [15:0] p0;
  int   outs0;

  // ---------------- random instances at WIDTH 4, 8, 16 ----------------
  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int W = (g == 0) ? 4 : ((g == 1) ? 8 : 16);
    logic [W-1:0]   a = '0, b = '0;
    logic           s = 1'b0, iv = 1'b0, ordy = 1'b1;
    logic           ov, irdy;
    logic [2*W-1:0] p;
    logic [31:0]    q[$];
    bit             done = 1'b0;

    vedic_mul_pipe #(.WIDTH(W)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(irdy), .in_a(a), .in_b(b),
      .in_signed(s), .out_valid(ov), .out_ready(ordy), .out_p(p)
    );

    initial begin
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          q.delete();
        end else begin
          if (ov && ordy) begin
            if (q.size() == 0) chk("rnd_unexpected_out", 32'd1, 32'd0);
            else chk("rnd_p", 32'(p), q.pop_front());
          end
          if (iv && irdy) q.push_back(ref_mul(W, longint'(a), longint'(b), s));
        end
      end
    end

    initial begin
      wait (rnd_go);
      tick();
      for (int c = 0; c < 4500; c++) begin
        iv   = ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 3) != 0);
        s    = 1'($urandom_range(0, 1));
        a    = W'($urandom);
        b    = W'($urandom);
        case ($urandom_range(0, 9))
          0: a = {1'b1, {(W-1){1'b0}}};
          1: b = {1'b1, {(W-1){1'b0}}};
          2: a = '0;
          3: b = '1;
          default: a = a;
        endcase
        tick();
      end
      iv = 1'b0;
      ordy = 1'b1;
      repeat (6) tick();
      chk("rnd_drain", 32'(q.size()), 32'd0);
      done = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    tbl[0] = '{8'd15,  8'd15,  1'b0, 16'h00E1};
    tbl[1] = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
    tbl[2] = '{8'h80,  8'h80,  1'b1, 16'h4000};
    tbl[3] = '{8'hFF,  8'h05,  1'b1, 16'hFFFB};
    tbl[4] = '{8'h00,  8'hF9,  1'b1, 16'h0000};
    tbl[5] = '{8'h7F,  8'h80,  1'b1, 16'hC080};
    tbl[6] = '{8'h80,  8'h01,  1'b1, 16'hFF80};
    tbl[7] = '{8'hFF,  8'hFF,  1'b1, 16'h0001};
    tbl[8] = '{8'h12,  8'h34,  1'b0, 16'h03A8};
    tbl[9] = '{8'h00,  8'hFF,  1'b0, 16'h0000};

    #12;
    chk("rst_out_valid", 32'(m_ov), 32'd0);
    chk("rst_out_p", 32'(m_p), 32'd0);
    chk("rst_in_ready", 32'(m_irdy), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_out_valid", 32'(m_ov), 32'd0);

    // Single ops: result appears exactly two edges after the operands are presented.
    for (int i = 0; i < 10; i++) begin
      m_a = tbl[i].a; m_b = tbl[i].b; m_s = tbl[i].s; m_iv = 1'b1;
      tick();
      m_iv = 1'b0;
      chk("lat1_valid", 32'(m_ov), 32'd0);
      tick();
      chk("lat2_valid", 32'(m_ov), 32'd1);
      chk("tbl_p", 32'(m_p), 32'(tbl[i].exp));
      tick();
      chk("single_pulse", 32'(m_ov), 32'd0);
    end

    // Back-to-back unsigned max then signed min*min.
    m_a = 8'hFF; m_b = 8'hFF; m_s = 1'b0; m_iv = 1'b1;
    tick();
    m_a = 8'h80; m_b = 8'h80; m_s = 1'b1;
    tick();
    m_iv = 1'b0;
    chk("b2b_first_valid", 32'(m_ov), 32'd1);
    chk("b2b_first_p", 32'(m_p), 32'h0000FE01);
    tick();
    chk("b2b_second_valid", 32'(m_ov), 32'd1);
    chk("b2b_second_p", 32'(m_p), 32'h00004000);
    tick();
    chk("b2b_idle", 32'(m_ov), 32'd0);

    // Stream of 4 ops with a 3-cycle downstream stall after the first result.
    outs0 = m_outs;
    sent_done = 1'b0;
    fork
      begin
        send(8'd3, 8'd7, 1'b0);
        send(8'hF0, 8'h10, 1'b1);
        send(8'd200, 8'd100, 1'b0);
        send(8'h81, 8'h7F, 1'b1);
        sent_done = 1'b1;
      end
    join_none
    for (int k = 0; k < 20 && !m_ov; k++) tick();
    chk("hold_first_valid", 32'(m_ov), 32'd1);
    chk("hold_first_p", 32'(m_p), 32'd21);
    m_ordy = 1'b0;
    p0 = m_p;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_p_stable", 32'(m_p), 32'(p0));
      chk("hold_valid", 32'(m_ov), 32'd1);
      chk("hold_in_ready", 32'(m_irdy), 32'd0);
    end
    m_ordy = 1'b1;
    for (int k = 0; k < 40 && !(sent_done && m_q.size() == 0 && !m_ov); k++) tick();
    chk("hold_count", 32'(m_outs - outs0), 32'd4);
    chk("hold_drain", 32'(m_q.size()), 32'd0);

    // Reset while two ops are in flight.
    m_ordy = 1'b0;
    send(8'd9, 8'd9, 1'b0);
    send(8'hFE, 8'd3, 1'b1);
    chk("pre_rst_valid", 32'(m_ov), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(m_ov), 32'd0);
    chk("mid_rst_p", 32'(m_p), 32'd0);
    chk("mid_rst_in_ready", 32'(m_irdy), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    m_ordy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("after_rst_no_stale", 32'(m_ov), 32'd0);
    end

    // Random phase on all widths.
    rnd_go = 1'b1;
    for (int k = 0; k < 20000 && !(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done); k++) tick();
    if (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done)) chk("rnd_timeout", 32'd0, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
